// File: rtl/cla_multiword_seq_ctrl.sv
// cla_multiword_seq_ctrl: multi-word add/subtract sequenced over one shared 16-bit CLA.
// The adder below is the 16-bit carry-lookahead datapath it reuses each cycle.
module cla_16bit_augmented (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_in,
   output logic [15:0] s,
   output logic        c_out
);
   always_comb begin
      logic [15:0] p, g, c;
      logic [4:0]  bc;
      logic [3:0]  bp, bg;
      p = a ^ b;
      g = a & b;
      bc[0] = c_in;
      c = '0;
      for (int k = 0; k < 4; k++) begin
         bp[k] = &p[4*k +: 4];
         bg[k] = g[4*k+3] | (p[4*k+3] & (g[4*k+2] | (p[4*k+2] & (g[4*k+1] | (p[4*k+1] & g[4*k])))));
         bc[k+1] = bg[k] | (bp[k] & bc[k]);
      end
      for (int k = 0; k < 4; k++) begin
         c[4*k] = bc[k];
         for (int j = 1; j < 4; j++)
            c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
      s = p ^ c;
      c_out = bc[4];
   end
endmodule

module cla_multiword_seq_ctrl #(
   parameter int NWORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic [16*NWORDS-1:0] op_a,
   input  logic [16*NWORDS-1:0] op_b,
   output logic                 ready,
   output logic                 done,
   output logic [16*NWORDS-1:0] result,
   output logic                 c_out,
   output logic                 overflow,
   output logic                 zero
);
   localparam int W  = 16 * NWORDS;
   localparam int IW = $clog2(NWORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [15:0]    sum;
   logic           sum_c;
   cla_16bit_augmented u_cla (
      .a    (a_q[idx_q*16 +: 16]),
      .b    (b_q[idx_q*16 +: 16]),
      .c_in (carry_q),
      .s    (sum),
      .c_out(sum_c)
   );
   // B is stored pre-inverted for subtract so the word loop is always an add.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      if (state_q == IDLE && start) begin
         a_d      = op_a;
         b_d      = op_b ^ {W{sub}};
         carry_d  = sub;
         idx_d    = '0;
         result_d = '0;
         state_d  = RUN;
      end else if (state_q == RUN) begin
         result_d[idx_q*16 +: 16] = sum;
         carry_d = sum_c;
         idx_d   = idx_q + 1'b1;
         if (idx_q == IW'(NWORDS - 1)) begin
            c_out_d = sum_c;
            ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[15] != a_q[W-1]);
            zero_d  = (result_d == '0);
            state_d = DONE;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end
   assign ready    = (state_q == IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
endmodule

// File: tb/tb_cla_multiword_seq_ctrl.sv
// tb_cla_multiword_seq_ctrl: vector table plus protocol sequences, checked through a scoreboard queue.
module tb_cla_multiword_seq_ctrl;
   localparam int NWORDS = 4;
   localparam int W = 16 * NWORDS;
   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         ovf;
      logic         z;
   } vec_t;
   typedef struct {
      vec_t v;
      int   t0;
   } exp_t;
   logic clk = 0, rst = 1, start = 0, sub = 0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic ready, done, c_out, overflow, zero;
   logic [W-1:0] result;
   int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
   bit chk_rdy = 0;
   exp_t exp_q[$];
   vec_t tbl[8];
   cla_multiword_seq_ctrl #(.NWORDS(NWORDS)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
      .ready(ready), .done(done), .result(result), .c_out(c_out),
      .overflow(overflow), .zero(zero)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   function automatic vec_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      logic [W-1:0] bp;
      logic [W:0] t;
      bp = b ^ {W{s}};
      t = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
      v.sub = s; v.a = a; v.b = b; v.res = t[W-1:0]; v.c = t[W];
      v.ovf = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
      v.z = (t[W-1:0] == '0);
      return v;
   endfunction
   always @(negedge clk) begin
      if (chk_rdy) chk("ready_after_done", {63'd0, ready}, 64'd1);
      chk_rdy = 0;
      if (done) begin
         done_cnt++;
         chk_rdy = 1;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("latency", 64'(cyc - e.t0), 64'd4);
            chk("result", result, e.v.res);
            chk("c_out", {63'd0, c_out}, {63'd0, e.v.c});
            chk("overflow", {63'd0, overflow}, {63'd0, e.v.ovf});
            chk("zero", {63'd0, zero}, {63'd0, e.v.z});
            chk("ready_in_done", {63'd0, ready}, 64'd0);
         end
      end
   end
   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!ready && n < 50) begin @(negedge clk); n++; end
      if (!ready) begin checks++; errors++; $display("FAIL ready_timeout actual=0 required=1"); end
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask
   task automatic launch(input vec_t v);
      op_a = v.a; op_b = v.b; sub = v.sub; start = 1;
      @(posedge clk);
      #1;
      exp_q.push_back('{v: v, t0: cyc});
   endtask
   task automatic scramble();
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; sub = 1'($urandom);
   endtask
   task automatic do_op(input vec_t v);
      wait_ready();
      launch(v);
      start = 0;
      scramble();
      drain();
   endtask
   initial begin
      vec_t v;
      int dc, prev, n;
      tbl[0] = '{0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0, 0, 0};
      tbl[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0, 1};
      tbl[2] = '{1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0};
      tbl[3] = '{1, 64'h1234, 64'h1234, 64'h0, 1, 0, 1};
      tbl[4] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 1, 0};
      tbl[5] = '{1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0};
      tbl[6] = '{0, 64'h1, 64'h2, 64'h3, 0, 0, 0};
      tbl[7] = '{1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0};
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_ready", {63'd0, ready}, 64'd1);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_flags", {61'd0, c_out, overflow, zero}, 64'd0);
      for (int i = 0; i < 8; i++) do_op(tbl[i]);
      for (int i = 0; i < 6; i++) do_op(model(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}));
      // Busy: start toggles operands every cycle, including the DONE cycle.
      dc = done_cnt;
      wait_ready();
      launch(model(0, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444));
      n = 0;
      do begin @(negedge clk); scramble(); start = 1; n++; end while (!ready && n < 20);
      start = 0;
      drain();
      repeat (8) @(negedge clk);
      chk("busy_single_done", 64'(done_cnt - dc), 64'd1);
      chk("busy_result", result, 64'h1234_6789_BCDF_1233);
      // Back-to-back with start held high.
      wait_ready();
      prev = 0;
      for (int k = 0; k < 3; k++) begin
         launch(tbl[k]);
         if (k > 0) chk("b2b_spacing", 64'(cyc - prev), 64'd6);
         prev = cyc;
         n = 0;
         if (k < 2) do begin @(negedge clk); n++; end while (!ready && n < 20);
      end
      start = 0;
      drain();
      // rst together with start.
      dc = done_cnt;
      @(negedge clk);
      rst = 1; start = 1; op_a = 64'h9; op_b = 64'h9; sub = 0;
      @(negedge clk);
      rst = 0; start = 0;
      repeat (7) @(negedge clk);
      chk("rst_start_ready", {63'd0, ready}, 64'd1);
      chk("rst_start_nodone", 64'(done_cnt - dc), 64'd0);
      // rst two cycles into RUN.
      wait_ready();
      op_a = 64'hFFFF_FFFF; op_b = 64'h1; sub = 0; start = 1;
      @(posedge clk);
      #1 start = 0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("abort_ready", {63'd0, ready}, 64'd1);
      chk("abort_result", result, 64'd0);
      chk("abort_flags", {62'd0, c_out, done}, 64'd0);
      repeat (8) @(negedge clk);
      chk("abort_nodone", 64'(done_cnt - dc), 64'd0);
      do_op(tbl[6]);
      chk("hold_result", result, 64'h3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cla_multiword_seq_ctrl.md
Name: cla_multiword_seq_ctrl

Overview:
- Sequencing controller that performs wide integer add/subtract by reusing a single internal 16-bit carry-lookahead adder (cla_16bit_augmented) over NWORDS consecutive cycles, one 16-bit word per cycle, least-significant word first.
- A carry register chains the carry between words.
- Sits between the ALU issue logic and the shared 16-bit adder datapath; gives multi-precision arithmetic without widening the adder.

Parameters:
- NWORDS, 4: number of 16-bit words per operand; operand width W = 16*NWORDS. Legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  W  sum/difference; held stable until the next accepted start.
- c_out  output  1  final carry out of word NWORDS-1. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow of the full W-bit operation.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, result=0, c_out=0, overflow=0, zero=0, word index=0, carry register=0.
- States: IDLE, RUN, DONE.

IDLE:
- ready=1.
- On start=1 at an edge:
  - latch op_a, and op_b XOR {W{sub}}.
  - latch sub.
  - carry register <= sub.
  - index <= 0.
  - result <= 0.
  - go to RUN.
- start=0: stay in IDLE; outputs hold.

RUN:
- ready=0.
- Adder inputs: in1 = A word[index], in2 = B' word[index], c_in = carry register.
- Each edge:
  - result word[index] <= adder s.
  - carry register <= adder c_out.
  - index <= index+1.
- At the edge where index = NWORDS-1:
  - c_out <= adder c_out.
  - overflow <= (A msb == B' msb) && (s msb != A msb).
  - zero computed from the complete result, including the word being written.
  - go to DONE.
- Adder p_out/g_out are unused.

DONE:
- done=1 for exactly one cycle; ready=0.
- Next edge: go to IDLE.
- start asserted during DONE is ignored.

Latency and throughput:
- With start sampled at edge E0, done is high during the cycle following edge E_NWORDS (NWORDS cycles later).
- ready returns at edge E_(NWORDS+1).
- Throughput: one operation per NWORDS+2 cycles.

Boundary conditions:
- start while ready=0: ignored; no latch; no effect on the in-flight operation.
- op_a/op_b/sub changing after acceptance: no effect (latched copies are used).
- rst during RUN or DONE: abort. Next cycle is IDLE with all outputs at reset values; done is not pulsed for the aborted operation.
- rst and start in the same cycle: rst wins; start is not accepted.
- Wrap-around: W-bit result is modulo 2^W; the carry/borrow is reported only through c_out.
- Subtract of equal operands: result 0, zero=1, c_out=1, overflow=0.
- result/c_out/overflow/zero: unchanged from DONE through IDLE until the next accepted start. Partial words are visible in result during RUN.

Test Plan (NWORDS=4):
1. Carry across a word boundary: add 0x0000_0000_0000_FFFF + 0x0000_0000_0000_0001 -> result 0x0000_0000_0001_0000, c_out=0, overflow=0, zero=0; done exactly 4 cycles after the start edge; ready high the cycle after done.
2. Full wrap: add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> result 0, c_out=1, zero=1, overflow=0.
3. Subtract with borrow: sub 0x5 - 0x7 -> result 0xFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0. Also 0x1234 - 0x1234 -> result 0, zero=1, c_out=1.
4. Signed overflow:
   - add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> 0x8000_0000_0000_0000, overflow=1, c_out=0.
   - sub 0x8000_0000_0000_0000 - 0x1 -> 0x7FFF_FFFF_FFFF_FFFF, overflow=1, c_out=1.
5. Protocol robustness:
   - Assert start with different operands on every cycle while busy, including the DONE cycle -> only the first operation executes; result matches the first operands.
   - Back-to-back: start held high continuously -> operations are accepted every 6 cycles.
6. Reset mid-operation:
   - Assert rst for one cycle two cycles into RUN -> next cycle ready=1, result=0, c_out=0, done never pulses.
   - A subsequent add 0x1 + 0x2 completes normally with result 0x3.
